// File: rtl/unsort_pkg.sv
// Shared defaults, FSM state type and slicing helper for the unsort5_seq restore path.
package unsort_pkg;

  localparam int unsigned DefW  = 4;
  localparam int unsigned DefN  = 5;
  localparam int unsigned DefIW = 3;

  typedef enum logic [1:0] {
    StIdle,
    StScatter,
    StDone
  } state_e;

  // Element 0 lives in the MSBs of a packed vector of n elements, each w bits wide.
  function automatic int unsigned elem_lsb(int unsigned k, int unsigned n, int unsigned w);
    return (n - 1 - k) * w;
  endfunction

endpackage

// File: rtl/unsort_idx_check.sv
// Tag checker: tracks which result slots were written and flags out-of-range or repeated indices.
module unsort_idx_check #(
  parameter int unsigned N  = 5,
  parameter int unsigned IW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  output logic          err
);

  logic [N-1:0] mask_q, mask_d;
  logic         err_q, err_d;

  always_comb begin
    mask_d = mask_q;
    err_d  = err_q;
    if (clear) begin
      mask_d = '0;
      err_d  = 1'b0;
    end else if (wr_en) begin
      if (wr_idx >= IW'(N)) begin
        err_d = 1'b1;
      end
      for (int s = 0; s < int'(N); s++) begin
        if (wr_idx == IW'(s)) begin
          if (mask_q[s]) err_d = 1'b1;
          mask_d[s] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q <= '0;
      err_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: rtl/unsort5_seq.sv
// Scatters a sorted vector back into original slot order, one element per cycle.
// Optional tag checking is enabled by defining UNSORT_CHECK_EN.
module unsort5_seq
  import unsort_pkg::*;
#(
  parameter int unsigned W  = DefW,
  parameter int unsigned N  = DefN,
  parameter int unsigned IW = DefIW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*W-1:0]  in_data,
  input  logic [N*IW-1:0] in_idx,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*W-1:0]  out_data,
  output logic            err
);

  state_e            state_q, state_d;
  logic [IW-1:0]     k_q, k_d;
  logic [N*W-1:0]    data_q, data_d;
  logic [N*IW-1:0]   idx_q, idx_d;
  logic [W-1:0]      buf_q [N];
  logic [W-1:0]      buf_d [N];
  logic [IW-1:0]     cur_idx;
  logic [W-1:0]      cur_val;
  logic              accept;
  logic              scatter_wr;

  assign cur_idx    = idx_q[elem_lsb(32'(k_q), N, IW) +: IW];
  assign cur_val    = data_q[elem_lsb(32'(k_q), N, W) +: W];
  assign accept     = (state_q == StIdle) && in_valid;
  assign scatter_wr = (state_q == StScatter);

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    data_d  = data_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          data_d = in_data;
          idx_d  = in_idx;
          k_d    = '0;
          for (int s = 0; s < int'(N); s++) buf_d[s] = '0;
          state_d = StScatter;
        end
      end
      StScatter: begin
        // Out-of-range indices match no slot, so the element is simply dropped.
        for (int s = 0; s < int'(N); s++) begin
          if (cur_idx == IW'(s)) buf_d[s] = cur_val;
        end
        k_d = k_q + IW'(1);
        if (k_q == IW'(N - 1)) begin
          k_d     = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      for (int s = 0; s < int'(N); s++) buf_q[s] <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      for (int s = 0; s < int'(N); s++) buf_q[s] <= buf_d[s];
    end
  end

  always_comb begin
    out_data = '0;
    for (int s = 0; s < int'(N); s++) begin
      out_data[elem_lsb(32'(s), N, W) +: W] = buf_q[s];
    end
  end

`ifdef UNSORT_CHECK_EN
  unsort_idx_check #(
    .N  (N),
    .IW (IW)
  ) u_idx_check (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .wr_en  (scatter_wr),
    .wr_idx (cur_idx),
    .err    (err)
  );
`else
  logic unused_chk;
  assign unused_chk = accept ^ scatter_wr;
  assign err        = 1'b0;
`endif

endmodule
